// File: rtl/pipe_latch_n_if.sv
// Handshake bundle between two pipeline stages: upstream valid/ready/data,
// downstream valid/ready/data, and the occupancy of the latch in between.
interface pipe_latch_n_if #(
  parameter int WIDTH  = 32,
  parameter int NUM_CH = 3
);
  logic                      in_valid;
  logic                      in_ready;
  logic [NUM_CH*WIDTH-1:0]   in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [NUM_CH*WIDTH-1:0]   out_data;
  logic [1:0]                occupancy;

  // The latch itself.
  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, occupancy
  );

  // Whatever surrounds the latch: producer on one side, consumer on the other.
  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/pipe_latch_n.sv
// Pipeline latch for NUM_CH channels of WIDTH bits with a valid/ready
// handshake. A main register M drives the output; a skid register S absorbs
// one extra bundle so in_ready depends only on registered state, never on
// out_ready. Flush inserts a bubble; occupancy reports 0, 1 or 2 entries.
module pipe_latch_n #(
  parameter int               WIDTH     = 32,
  parameter int               NUM_CH    = 3,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           enable,
  input  logic           flush,
  pipe_latch_n_if.slave  bus
);

  localparam int              BW           = NUM_CH * WIDTH;
  localparam logic [BW-1:0]   FLUSH_BUNDLE = {NUM_CH{FLUSH_VAL}};

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [BW-1:0]   m_q, m_d;
  logic [BW-1:0]   s_q, s_d;
  logic            acc;
  logic            tk;

  generate
    if (WIDTH < 1 || NUM_CH < 1) begin : g_param_check
      $error("pipe_latch_n: WIDTH and NUM_CH must both be at least 1");
    end
  endgenerate

  // Handshake decode: ready and valid come from registered state only, and
  // out_data shows the bubble value whenever nothing valid is presented.
  assign bus.in_ready  = enable & ~reset & (state_q != FULL);
  assign bus.out_valid = enable & (state_q != EMPTY);
  assign bus.out_data  = bus.out_valid ? m_q : FLUSH_BUNDLE;
  assign bus.occupancy = state_q;

  assign acc = bus.in_valid  & bus.in_ready;
  assign tk  = bus.out_valid & bus.out_ready;

  // Next-state and next-data selection; acc/tk are already gated by enable.
  always_comb begin
    // NOTE: every signal gets a hold value first so no path leaves it unassigned (no latch).
    state_d = state_q;
    m_d     = m_q;
    s_d     = s_q;
    if (flush) begin
      state_d = EMPTY;
      m_d     = FLUSH_BUNDLE;
      s_d     = FLUSH_BUNDLE;
    end else begin
      case (state_q)
        EMPTY: begin
          if (acc) begin
            m_d     = bus.in_data;
            state_d = BUSY;
          end
        end
        BUSY: begin
          if (acc && tk) begin
            m_d = bus.in_data;
          end else if (acc) begin
            s_d     = bus.in_data;
            state_d = FULL;
          end else if (tk) begin
            m_d     = FLUSH_BUNDLE;
            state_d = EMPTY;
          end
        end
        FULL: begin
          if (tk) begin
            m_d     = s_q;
            s_d     = FLUSH_BUNDLE;
            state_d = BUSY;
          end
        end
        default: begin
          state_d = EMPTY;
          m_d     = FLUSH_BUNDLE;
          s_d     = FLUSH_BUNDLE;
        end
      endcase
    end
  end

  // State and data registers with synchronous reset taking priority over all else.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset) begin
      state_q <= EMPTY;
      // NOTE: the data registers are reset too, so both entries hold the bubble value.
      m_q     <= FLUSH_BUNDLE;
      s_q     <= FLUSH_BUNDLE;
    end else begin
      state_q <= state_d;
      m_q     <= m_d;
      s_q     <= s_d;
    end
  end

endmodule

// File: tb/tb_pipe_latch_n.sv
// Bench for pipe_latch_n: a vector table on the default 32x3 instance, a
// random sweep on an 8x5 instance with FLUSH_VAL=8'hFF, and a queue-based
// reference model per instance that checks ordering, occupancy and handshake.
module tb_pipe_latch_n;

  localparam int AW = 32 * 3;
  localparam int BWB = 8 * 5;
  localparam logic [BWB-1:0] B_IDLE = {5{8'hFF}};

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic a_rst, a_en, a_fl;
  logic b_rst, b_en, b_fl;

  int n_checks = 0;
  int n_fail   = 0;

  pipe_latch_n_if #(.WIDTH(32), .NUM_CH(3)) bus_a ();
  pipe_latch_n_if #(.WIDTH(8),  .NUM_CH(5)) bus_b ();

  pipe_latch_n #(.WIDTH(32), .NUM_CH(3), .FLUSH_VAL(32'h0)) u_a (
    .clock  (clock),
    .reset  (a_rst),
    .enable (a_en),
    .flush  (a_fl),
    .bus    (bus_a)
  );

  pipe_latch_n #(.WIDTH(8), .NUM_CH(5), .FLUSH_VAL(8'hFF)) u_b (
    .clock  (clock),
    .reset  (b_rst),
    .enable (b_en),
    .flush  (b_fl),
    .bus    (bus_b)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, wanted %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] rep(input logic [31:0] x);
    return {3{x}};
  endfunction

  function automatic logic [AW-1:0] bun(input int k);
    logic [31:0] kk;
    kk = 32'(k);
    return {32'hC000_0000 | kk, 32'hB000_0000 | kk, 32'hA000_0000 | kk};
  endfunction

  typedef struct {
    logic          rst, en, fl, iv;
    logic [AW-1:0] din;
    logic          ordy;
    logic          exp_ir, exp_ov;
    logic [1:0]    exp_occ;
    logic [AW-1:0] exp_od;
  } vec_t;

  function automatic vec_t mkv(input logic rst, en, fl, iv, input logic [AW-1:0] din,
                               input logic ordy, ir, ov, input logic [1:0] occ,
                               input logic [AW-1:0] od);
    vec_t v;
    v.rst = rst; v.en = en; v.fl = fl; v.iv = iv; v.din = din; v.ordy = ordy;
    v.exp_ir = ir; v.exp_ov = ov; v.exp_occ = occ; v.exp_od = od;
    return v;
  endfunction

  // Reference model for instance A: one queue entry per held bundle.
  logic [AW-1:0] qa[$];
  logic          a_eir, a_eov;
  always @(negedge clock) begin
    a_eir = a_en && !a_rst && (qa.size() < 2);
    a_eov = a_en && (qa.size() > 0);
    check("a_in_ready",  128'(bus_a.in_ready),  128'(a_eir));
    check("a_out_valid", 128'(bus_a.out_valid), 128'(a_eov));
    check("a_occupancy", 128'(bus_a.occupancy), 128'(qa.size()));
    if (!a_eov) check("a_idle_data", 128'(bus_a.out_data), 128'(0));
    if (a_rst || a_fl) begin
      qa.delete();
    end else begin
      if (a_eov && bus_a.out_ready) begin
        check("a_sb_data", 128'(bus_a.out_data), 128'(qa[0]));
        void'(qa.pop_front());
      end
      if (bus_a.in_valid && a_eir) qa.push_back(bus_a.in_data);
    end
  end

  // Reference model for instance B.
  logic [BWB-1:0] qb[$];
  logic           b_eir, b_eov;
  always @(negedge clock) begin
    b_eir = b_en && !b_rst && (qb.size() < 2);
    b_eov = b_en && (qb.size() > 0);
    check("b_in_ready",  128'(bus_b.in_ready),  128'(b_eir));
    check("b_out_valid", 128'(bus_b.out_valid), 128'(b_eov));
    check("b_occupancy", 128'(bus_b.occupancy), 128'(qb.size()));
    if (!b_eov) check("b_idle_data", 128'(bus_b.out_data), 128'(B_IDLE));
    if (b_rst || b_fl) begin
      qb.delete();
    end else begin
      if (b_eov && bus_b.out_ready) begin
        check("b_sb_data", 128'(bus_b.out_data), 128'(qb[0]));
        void'(qb.pop_front());
      end
      if (bus_b.in_valid && b_eir) qb.push_back(bus_b.in_data);
    end
  end

  vec_t          vt[$];
  logic [63:0]   r64;
  logic [AW-1:0] z;

  initial begin
    a_rst = 1'b1; a_en = 1'b1; a_fl = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.in_data = '0; bus_a.out_ready = 1'b1;
    b_rst = 1'b1; b_en = 1'b1; b_fl = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.in_data = '0; bus_b.out_ready = 1'b1;
    z = '0;

    // Reset for two cycles, then a four-bundle stream with out_ready held high.
    vt.push_back(mkv(1,1,0,0,z,1,        0,0,2'd0,z));
    vt.push_back(mkv(1,1,0,0,z,1,        0,0,2'd0,z));
    vt.push_back(mkv(0,1,0,1,bun(0),1,   1,0,2'd0,z));
    vt.push_back(mkv(0,1,0,1,bun(1),1,   1,1,2'd1,bun(0)));
    vt.push_back(mkv(0,1,0,1,bun(2),1,   1,1,2'd1,bun(1)));
    vt.push_back(mkv(0,1,0,1,bun(3),1,   1,1,2'd1,bun(2)));
    vt.push_back(mkv(0,1,0,0,z,1,        1,1,2'd1,bun(3)));
    vt.push_back(mkv(0,1,0,0,z,0,        1,0,2'd0,z));
    // Backpressure fill to FULL, then release in order.
    vt.push_back(mkv(0,1,0,1,rep(32'h11),0, 1,0,2'd0,z));
    vt.push_back(mkv(0,1,0,1,rep(32'h22),0, 1,1,2'd1,rep(32'h11)));
    vt.push_back(mkv(0,1,0,1,rep(32'h33),0, 0,1,2'd2,rep(32'h11)));
    vt.push_back(mkv(0,1,0,1,rep(32'h33),1, 0,1,2'd2,rep(32'h11)));
    vt.push_back(mkv(0,1,0,1,rep(32'h33),1, 1,1,2'd1,rep(32'h22)));
    vt.push_back(mkv(0,1,0,0,z,1,           1,1,2'd1,rep(32'h33)));
    // Drain a single entry to empty.
    vt.push_back(mkv(0,1,0,1,rep(32'h5A),0, 1,0,2'd0,z));
    vt.push_back(mkv(0,1,0,0,z,1,           1,1,2'd1,rep(32'h5A)));
    vt.push_back(mkv(0,1,0,0,z,0,           1,0,2'd0,z));
    // Flush while FULL with 0x77 on offer.
    vt.push_back(mkv(0,1,0,1,rep(32'h01),0, 1,0,2'd0,z));
    vt.push_back(mkv(0,1,0,1,rep(32'h02),0, 1,1,2'd1,rep(32'h01)));
    vt.push_back(mkv(0,1,1,1,rep(32'h77),1, 0,1,2'd2,rep(32'h01)));
    vt.push_back(mkv(0,1,0,0,z,0,           1,0,2'd0,z));
    // Flush in BUSY discards a same-cycle accept and take.
    vt.push_back(mkv(0,1,0,1,rep(32'h44),0, 1,0,2'd0,z));
    vt.push_back(mkv(0,1,1,1,rep(32'h55),1, 1,1,2'd1,rep(32'h44)));
    vt.push_back(mkv(0,1,0,0,z,0,           1,0,2'd0,z));
    // Enable freeze for three cycles.
    vt.push_back(mkv(0,1,0,1,rep(32'hDEAD),0, 1,0,2'd0,z));
    vt.push_back(mkv(0,0,0,1,rep(32'hBEEF),1, 0,0,2'd1,z));
    vt.push_back(mkv(0,0,0,1,rep(32'hBEEF),1, 0,0,2'd1,z));
    vt.push_back(mkv(0,0,0,1,rep(32'hBEEF),1, 0,0,2'd1,z));
    vt.push_back(mkv(0,1,0,0,z,0,             1,1,2'd1,rep(32'hDEAD)));
    // Reset while disabled and FULL.
    vt.push_back(mkv(0,1,0,1,rep(32'h66),0, 1,1,2'd1,rep(32'hDEAD)));
    vt.push_back(mkv(0,0,0,0,z,0,           0,0,2'd2,z));
    vt.push_back(mkv(1,0,0,0,z,0,           0,0,2'd2,z));
    vt.push_back(mkv(0,1,0,0,z,0,           1,0,2'd0,z));
    // Flush while disabled.
    vt.push_back(mkv(0,1,0,1,rep(32'h12),0, 1,0,2'd0,z));
    vt.push_back(mkv(0,0,1,0,z,0,           0,0,2'd1,z));
    vt.push_back(mkv(0,1,0,0,z,1,           1,0,2'd0,z));

    foreach (vt[i]) begin
      @(posedge clock); #1;
      a_rst = vt[i].rst; a_en = vt[i].en; a_fl = vt[i].fl;
      bus_a.in_valid = vt[i].iv; bus_a.in_data = vt[i].din; bus_a.out_ready = vt[i].ordy;
      @(negedge clock);
      check($sformatf("v%0d_in_ready", i),  128'(bus_a.in_ready),  128'(vt[i].exp_ir));
      check($sformatf("v%0d_out_valid", i), 128'(bus_a.out_valid), 128'(vt[i].exp_ov));
      check($sformatf("v%0d_occupancy", i), 128'(bus_a.occupancy), 128'(vt[i].exp_occ));
      check($sformatf("v%0d_out_data", i),  128'(bus_a.out_data),  128'(vt[i].exp_od));
    end

    @(posedge clock); #1;
    a_rst = 1'b0; a_en = 1'b1; a_fl = 1'b0;
    bus_a.in_valid = 1'b0; bus_a.out_ready = 1'b1;

    // Random traffic on the 8x5 instance with a reset in mid-stream.
    for (int c = 0; c < 1000; c++) begin
      @(posedge clock); #1;
      b_rst = (c == 500) || (c == 501) || (c == 0);
      b_en  = ($urandom_range(0, 15) != 0);
      b_fl  = ($urandom_range(0, 63) == 0);
      bus_b.in_valid  = ($urandom_range(0, 3) != 0);
      r64 = {$urandom, $urandom};
      bus_b.in_data   = r64[BWB-1:0];
      bus_b.out_ready = ($urandom_range(0, 2) != 0);
    end

    // Drain what is left, then confirm the instance ends empty.
    @(posedge clock); #1;
    b_rst = 1'b0; b_en = 1'b1; b_fl = 1'b0;
    bus_b.in_valid = 1'b0; bus_b.out_ready = 1'b1;
    repeat (4) @(posedge clock);
    @(negedge clock);
    check("b_final_occupancy", 128'(bus_b.occupancy), 128'(0));
    check("b_final_data", 128'(bus_b.out_data), 128'(B_IDLE));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
